ascon_perm: RTL and testbench



---
 rtl/ascon_perm_pkg.sv | 52 +++++
 rtl/ascon_perm_round.sv | 34 +++
 rtl/ascon_perm.sv | 95 +++++++++
 tb/tb_ascon_perm.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ascon_perm_pkg.sv
// rtl/ascon_perm_pkg.sv - Ascon shared types, round constants, S-box and rotation amounts
package ascon_perm_pkg;

  localparam int RND_WIDTH  = 4;
  localparam int MAX_ROUNDS = 12;

  typedef logic [7:0]       u8_t;
  typedef logic [63:0]      u64_t;
  // Element 0 is x0, element 4 is x4.
  typedef logic [4:0][63:0] ascon_state_t;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} perm_state_e;

  localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic u8_t rnd_const(input logic [RND_WIDTH-1:0] idx);
    case (idx)
      4'd0:    return 8'hf0;
      4'd1:    return 8'he1;
      4'd2:    return 8'hd2;
      4'd3:    return 8'hc3;
      4'd4:    return 8'hb4;
      4'd5:    return 8'ha5;
      4'd6:    return 8'h96;
      4'd7:    return 8'h87;
      4'd8:    return 8'h78;
      4'd9:    return 8'h69;
      4'd10:   return 8'h5a;
      4'd11:   return 8'h4b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [4:0] sbox(input logic [4:0] v);
    case (v)
      5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
      5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
      5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
      5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
      5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
      5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
      5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
      5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
    endcase
  endfunction

  function automatic u64_t ror64(input u64_t x, input int unsigned r);
    return (x >> r) | (x << (64 - r));
  endfunction

endpackage

// File: rtl/ascon_perm_round.sv
// rtl/ascon_perm_round.sv - one combinational Ascon round: constant add, S-box, linear layer
module ascon_round
  import ascon_perm_pkg::*;
(
  input  ascon_state_t state_i,
  input  u8_t          rc_i,
  output ascon_state_t state_o
);

  ascon_state_t s_add;
  ascon_state_t s_sub;

  always_comb begin
    logic [4:0] w;
    w        = '0;
    s_add    = state_i;
    s_add[2] = state_i[2] ^ {56'd0, rc_i};
    s_sub    = s_add;
    // The S-box works on bit columns across the five lanes, x0 as the MSB.
    for (int j = 0; j < 64; j++) begin
      w = sbox({s_add[0][j], s_add[1][j], s_add[2][j], s_add[3][j], s_add[4][j]});
      s_sub[0][j] = w[4];
      s_sub[1][j] = w[3];
      s_sub[2][j] = w[2];
      s_sub[3][j] = w[1];
      s_sub[4][j] = w[0];
    end
    state_o = s_sub;
    for (int k = 0; k < 5; k++) begin
      state_o[k] = s_sub[k] ^ ror64(s_sub[k], ROT_A[k]) ^ ror64(s_sub[k], ROT_B[k]);
    end
  end

endmodule

// File: rtl/ascon_perm.sv
// rtl/ascon_perm.sv - iterative Ascon permutation p^n, one round per clock
module ascon_perm
  import ascon_perm_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [RND_WIDTH-1:0] rounds_i,
  input  ascon_state_t         state_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output ascon_state_t         state_o
);

  localparam logic [RND_WIDTH-1:0] MAX_N = RND_WIDTH'(MAX_ROUNDS);
  localparam logic [RND_WIDTH-1:0] ONE   = RND_WIDTH'(1);

  perm_state_e          fsm;
  logic [RND_WIDTH-1:0] remaining;
  logic [RND_WIDTH-1:0] rc_idx;
  logic [RND_WIDTH-1:0] n_clamped;
  logic [RND_WIDTH-1:0] start_idx;
  ascon_state_t         state_q;
  ascon_state_t         round_in;
  ascon_state_t         round_out;
  u8_t                  rc;

  assign n_clamped = (rounds_i > MAX_N) ? MAX_N : rounds_i;
  assign start_idx = MAX_N - n_clamped;

  // The first round is applied straight from state_i on the accepting edge.
  assign round_in = (fsm == ST_BUSY) ? state_q : state_i;
  assign rc       = rnd_const((fsm == ST_BUSY) ? rc_idx : start_idx);
  assign state_o  = state_q;

  ascon_round u_round (
    .state_i (round_in),
    .rc_i    (rc),
    .state_o (round_out)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm       <= ST_IDLE;
      state_q   <= '0;
      remaining <= '0;
      rc_idx    <= '0;
      ready_o   <= 1'b1;
      valid_o   <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            rc_idx <= start_idx + ONE;
            if (n_clamped == '0) begin
              state_q   <= state_i;
              remaining <= '0;
              fsm       <= ST_DONE;
              ready_o   <= 1'b1;
              valid_o   <= 1'b1;
            end else if (n_clamped == ONE) begin
              state_q   <= round_out;
              remaining <= '0;
              fsm       <= ST_DONE;
              ready_o   <= 1'b1;
              valid_o   <= 1'b1;
            end else begin
              state_q   <= round_out;
              remaining <= n_clamped - ONE;
              fsm       <= ST_BUSY;
              ready_o   <= 1'b0;
              valid_o   <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          state_q   <= round_out;
          rc_idx    <= rc_idx + ONE;
          remaining <= remaining - ONE;
          if (remaining == ONE) begin
            fsm     <= ST_DONE;
            ready_o <= 1'b1;
            valid_o <= 1'b1;
          end
        end
        default: begin
          fsm     <= ST_IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_perm.sv
// tb/tb_ascon_perm.sv - randomized self-checking bench for ascon_perm against a bitsliced model
module tb_ascon_perm;
  import ascon_perm_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   rounds = '0;
  ascon_state_t state_in = '0;
  logic         ready;
  logic         valid;
  ascon_state_t state_out;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  ascon_perm dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .rounds_i (rounds),
    .state_i  (state_in),
    .ready_o  (ready),
    .valid_o  (valid),
    .state_o  (state_out)
  );

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rot(input logic [63:0] v, input int r);
    return (v >> r) | (v << (64 - r));
  endfunction

  // Bitsliced reference: constants from ((15-i)<<4)|i, S-box as boolean equations.
  function automatic ascon_state_t model_perm(input ascon_state_t s, input int n);
    logic [63:0] x [5];
    logic [63:0] t [5];
    int nn;
    ascon_state_t r;
    nn = (n > 12) ? 12 : n;
    for (int k = 0; k < 5; k++) x[k] = s[k];
    for (int i = 12 - nn; i < 12; i++) begin
      x[2] = x[2] ^ 64'(((15 - i) << 4) | i);
      x[0] = x[0] ^ x[4]; x[4] = x[4] ^ x[3]; x[2] = x[2] ^ x[1];
      for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
      for (int k = 0; k < 5; k++) x[k] = x[k] ^ t[(k + 1) % 5];
      x[1] = x[1] ^ x[0]; x[0] = x[0] ^ x[4]; x[3] = x[3] ^ x[2]; x[2] = ~x[2];
      x[0] = x[0] ^ rot(x[0], 19) ^ rot(x[0], 28);
      x[1] = x[1] ^ rot(x[1], 61) ^ rot(x[1], 39);
      x[2] = x[2] ^ rot(x[2], 1)  ^ rot(x[2], 6);
      x[3] = x[3] ^ rot(x[3], 10) ^ rot(x[3], 17);
      x[4] = x[4] ^ rot(x[4], 7)  ^ rot(x[4], 41);
    end
    for (int k = 0; k < 5; k++) r[k] = x[k];
    return r;
  endfunction

  function automatic ascon_state_t rand_state();
    ascon_state_t s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  // Starts one op in the next low phase and follows it to valid; optionally pokes start while busy.
  task automatic do_op(input string tag, input ascon_state_t s, input logic [3:0] n, input int poke_at);
    int edges;
    int exp_lat;
    ascon_state_t exp_state;
    exp_state = model_perm(s, int'(n));
    exp_lat   = ((n > 12) ? 12 : ((n == 0) ? 1 : int'(n))) - 1;
    @(negedge clk);
    start = 1'b1; rounds = n; state_in = s;
    @(posedge clk); #1;
    start = 1'b0; rounds = 4'($urandom); state_in = rand_state();
    if (exp_lat > 0) chk({tag, "_valid_drop"}, 320'(valid), 320'(0));
    edges = 0;
    while (!valid && edges < 20) begin
      chk({tag, "_ready_busy"}, 320'(ready), 320'(0));
      if (edges == poke_at) begin
        start = 1'b1; rounds = 4'd1; state_in = rand_state();
      end
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
    end
    chk({tag, "_latency"}, 320'(edges), 320'(exp_lat));
    chk({tag, "_ready"}, 320'(ready), 320'(1));
    chk({tag, "_state"}, state_out, exp_state);
  endtask

  initial begin
    ascon_state_t s;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 320'(ready), 320'(1));
    chk("reset_valid", 320'(valid), 320'(0));
    chk("reset_state", state_out, 320'(0));
    @(negedge clk); rst_n = 1'b1;

    do_op("zero_n1", '0, 4'd1, -1);

    s[0] = 64'h80400c0600000000;
    s[1] = 64'h0001020304050607;
    s[2] = 64'h08090a0b0c0d0e0f;
    s[3] = 64'h0001020304050607;
    s[4] = 64'h08090a0b0c0d0e0f;
    do_op("init_p12", s, 4'd12, -1);

    do_op("rand_n6", rand_state(), 4'd6, -1);
    do_op("rand_n8", rand_state(), 4'd8, -1);
    do_op("rand_n0", rand_state(), 4'd0, -1);
    do_op("rand_n15", rand_state(), 4'd15, -1);
    do_op("rand_n2", rand_state(), 4'd2, -1);
    do_op("busy_poke", rand_state(), 4'd12, 3);
    do_op("busy_poke_last", rand_state(), 4'd5, 3);

    // Reset lands after round 5 of 12 has been applied.
    @(negedge clk);
    start = 1'b1; rounds = 4'd12; state_in = rand_state();
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 320'(ready), 320'(1));
    chk("midrst_valid", 320'(valid), 320'(0));
    chk("midrst_state", state_out, 320'(0));
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_valid", 320'(valid), 320'(0));
    do_op("after_rst", rand_state(), 4'd12, -1);

    for (int i = 0; i < 20; i++) begin
      do_op("rand_loop", rand_state(), 4'($urandom_range(0, 15)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
